// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit and receive paths.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_parity_calc.sv
// Combinational parity generator, shared by the TX and RX paths.
module uart_parity_calc
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  par_typ,
    output logic                  par_bit
);

    // Even parity makes the total count of ones even, so the bit equals the XOR of the data.
    assign par_bit = (^data) ^ (par_typ == PAR_ODD);

endmodule

// File: rtl/uart_tx_framer.sv
// UART transmit framer: start bit, DATA_WIDTH data bits, optional parity, STOP_BITS stop bits.
// Bit timing comes from the external one-cycle TX_tick strobe.
module uart_tx_framer
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int STOP_BITS  = 1,
    parameter bit MSB_FIRST  = 1'b0
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  TX_tick,
    input  logic [DATA_WIDTH-1:0] TX_DATA,
    input  logic                  TX_valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  tx_ready,
    output logic                  ser_out,
    output logic                  busy,
    output logic                  ser_done
);

    localparam int                CNT_W     = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0]  BIT_MAX   = CNT_W'(DATA_WIDTH);
    localparam logic              STOP_LAST = 1'(STOP_BITS - 1);

    tx_state_t             state, state_nxt;
    logic [DATA_WIDTH-1:0] shift_q, shift_nxt;
    logic [CNT_W-1:0]      bit_cnt, bit_cnt_nxt;
    logic                  stop_cnt, stop_cnt_nxt;
    logic                  par_en_q, par_bit_q, par_bit;
    logic                  ser_out_nxt, ser_done_nxt;
    logic                  accept;

    assign accept = TX_valid && tx_ready;
    assign busy   = ~tx_ready;

    uart_parity_calc #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_parity (
        .data    (TX_DATA),
        .par_typ (PAR_TYP),
        .par_bit (par_bit)
    );

    // NOTE: sequential state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of process evaluation order.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)  state_nxt = ARM;
            ARM:     if (TX_tick) state_nxt = START;
            START:   if (TX_tick) state_nxt = DATA;
            DATA:    if (TX_tick && bit_cnt == LAST_BIT) state_nxt = par_en_q ? PARITY : STOP;
            PARITY:  if (TX_tick) state_nxt = STOP;
            STOP:    if (TX_tick && stop_cnt == STOP_LAST) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        shift_nxt    = shift_q;
        bit_cnt_nxt  = bit_cnt;
        stop_cnt_nxt = stop_cnt;
        if (state == IDLE && accept) begin
            shift_nxt = TX_DATA;
        end
        if (state == START && TX_tick) begin
            bit_cnt_nxt = '0;
        end
        if (state == DATA && TX_tick) begin
            shift_nxt   = MSB_FIRST ? (shift_q << 1) : (shift_q >> 1);
            bit_cnt_nxt = (bit_cnt == BIT_MAX) ? bit_cnt : bit_cnt + CNT_W'(1);
        end
        if (state_nxt == STOP && state != STOP) begin
            stop_cnt_nxt = 1'b0;
        end else if (state == STOP && TX_tick) begin
            stop_cnt_nxt = (stop_cnt == STOP_LAST) ? 1'b0 : stop_cnt + 1'b1;
        end
    end

    // The line value is decoded from the upcoming state so the registered pin changes on the
    // same edge as the FSM.
    always_comb begin
        ser_out_nxt = 1'b1;
        case (state_nxt)
            START:   ser_out_nxt = 1'b0;
            DATA:    ser_out_nxt = MSB_FIRST ? shift_nxt[DATA_WIDTH-1] : shift_nxt[0];
            PARITY:  ser_out_nxt = par_bit_q;
            default: ser_out_nxt = 1'b1;
        endcase
        ser_done_nxt = (state == STOP) && (state_nxt == IDLE);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            shift_q   <= '0;
            bit_cnt   <= '0;
            stop_cnt  <= 1'b0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            ser_out   <= 1'b1;
            ser_done  <= 1'b0;
            tx_ready  <= 1'b1;
        end else begin
            shift_q  <= shift_nxt;
            bit_cnt  <= bit_cnt_nxt;
            stop_cnt <= stop_cnt_nxt;
            if (state == IDLE && accept) begin
                par_en_q  <= PAR_EN;
                par_bit_q <= par_bit;
            end
            ser_out  <= ser_out_nxt;
            ser_done <= ser_done_nxt;
            tx_ready <= (state_nxt == IDLE);
        end
    end

endmodule

// File: tb/tb_uart_tx_framer.sv
// Self-checking bench for uart_tx_framer: an 8N1 instance and a 5-bit MSB-first, 2-stop instance.
module tb_uart_tx_framer;
    import uart_pkg::*;

    typedef struct {
        logic [7:0] data;
        logic       par_en;
        logic       par_typ;
        string      exp_bits;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick_gen, tick_force;
    logic       tx_tick;
    logic [7:0] data8;
    logic [4:0] data5;
    logic       valid8, valid5, par_en, par_typ;
    logic       tx_ready8, ser_out8, busy8, ser_done8;
    logic       tx_ready5, ser_out5, busy5, ser_done5;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int done8 = 0, done5 = 0, done8_cyc = 0, done5_cyc = 0, popped8 = 0;
    bit busy8_prev = 1'b0, busy5_prev = 1'b0;
    bit tick_hold = 1'b0, tick_periodic = 1'b1;
    int div = 0;
    bit q8[$];
    bit q5[$];
    vec_t vecs[6];

    assign tx_tick = tick_gen | tick_force;

    uart_tx_framer #(.DATA_WIDTH(8), .STOP_BITS(1), .MSB_FIRST(1'b0)) dut8 (
        .CLK(clk), .RST(rst), .TX_tick(tx_tick), .TX_DATA(data8), .TX_valid(valid8),
        .PAR_EN(par_en), .PAR_TYP(par_typ), .tx_ready(tx_ready8), .ser_out(ser_out8),
        .busy(busy8), .ser_done(ser_done8)
    );

    uart_tx_framer #(.DATA_WIDTH(5), .STOP_BITS(2), .MSB_FIRST(1'b1)) dut5 (
        .CLK(clk), .RST(rst), .TX_tick(tx_tick), .TX_DATA(data5), .TX_valid(valid5),
        .PAR_EN(par_en), .PAR_TYP(par_typ), .tx_ready(tx_ready5), .ser_out(ser_out5),
        .busy(busy5), .ser_done(ser_done5)
    );

    initial forever #5 clk = ~clk;

    // Baud strobe: every 4th cycle, or held high, updated on the falling edge.
    initial begin
        tick_gen = 1'b0;
        forever begin
            @(negedge clk);
            div++;
            tick_gen = tick_hold || (tick_periodic && (div % 4 == 0));
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event did not occur within its bound (t=%0t)", name, $time);
    endtask

    function automatic string frame8n1(input logic [7:0] d);
        string s;
        s = "0";
        for (int i = 0; i < 8; i++) begin
            if (d[i]) s = {s, "1"};
            else      s = {s, "0"};
        end
        s = {s, "1"};
        return s;
    endfunction

    // Monitor: every tick edge inside a frame yields one line bit, compared against the scoreboard.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (!rst) begin
                check("dut8_busy_vs_ready", busy8, !tx_ready8);
                check("dut5_busy_vs_ready", busy5, !tx_ready5);
                if (tx_tick && busy8_prev && busy8) begin
                    if (q8.size() == 0) fail_now("dut8_unexpected_bit");
                    else check("dut8_ser_bit", ser_out8, q8.pop_front());
                    popped8++;
                end
                if (tx_tick && busy5_prev && busy5) begin
                    if (q5.size() == 0) fail_now("dut5_unexpected_bit");
                    else check("dut5_ser_bit", ser_out5, q5.pop_front());
                end
                if (ser_done8) begin
                    done8++;
                    done8_cyc = cyc;
                end
                if (ser_done5) begin
                    done5++;
                    done5_cyc = cyc;
                end
            end
            busy8_prev = busy8;
            busy5_prev = busy5;
        end
    end

    task automatic send(input bit sel, input logic [7:0] d, input logic pe, input logic pt,
                        input string exp, output int acc_cyc);
        int n;
        n = 0;
        @(negedge clk);
        par_en  = pe;
        par_typ = pt;
        if (sel) begin
            data5  = d[4:0];
            valid5 = 1'b1;
        end else begin
            data8  = d;
            valid8 = 1'b1;
        end
        for (int i = 0; i < exp.len(); i++) begin
            if (sel) q5.push_back(exp[i] == "1");
            else     q8.push_back(exp[i] == "1");
        end
        while (!(sel ? tx_ready5 : tx_ready8) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) begin
            fail_now("accept_timeout");
            acc_cyc = -1;
            valid8  = 1'b0;
            valid5  = 1'b0;
            return;
        end
        @(negedge clk);
        acc_cyc = cyc;
        valid8  = 1'b0;
        valid5  = 1'b0;
        check(sel ? "dut5_ready_drop" : "dut8_ready_drop", sel ? tx_ready5 : tx_ready8, 0);
    endtask

    task automatic wait_done(input bit sel, input int budget);
        int start;
        int n;
        start = sel ? done5 : done8;
        n = 0;
        while ((sel ? done5 : done8) == start && n < budget) begin
            @(negedge clk);
            n++;
        end
        if ((sel ? done5 : done8) == start) fail_now(sel ? "dut5_done_timeout" : "dut8_done_timeout");
    endtask

    initial begin
        int d0, p0, acc, acc2, n;

        vecs[0] = '{data: 8'hA5, par_en: 1'b0, par_typ: PAR_EVEN, exp_bits: "0101001011"};
        vecs[1] = '{data: 8'h07, par_en: 1'b1, par_typ: PAR_EVEN, exp_bits: "01110000011"};
        vecs[2] = '{data: 8'h07, par_en: 1'b1, par_typ: PAR_ODD,  exp_bits: "01110000001"};
        vecs[3] = '{data: 8'hA5, par_en: 1'b1, par_typ: PAR_EVEN, exp_bits: "01010010101"};
        vecs[4] = '{data: 8'h00, par_en: 1'b1, par_typ: PAR_ODD,  exp_bits: "00000000011"};
        vecs[5] = '{data: 8'hFF, par_en: 1'b0, par_typ: PAR_EVEN, exp_bits: "0111111111"};

        rst = 1'b1;
        tick_force = 1'b0;
        data8 = '0; data5 = '0; valid8 = 1'b0; valid5 = 1'b0; par_en = 1'b0; par_typ = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ser_out8", ser_out8, 1);
        check("rst_tx_ready8", tx_ready8, 1);
        check("rst_busy8", busy8, 0);
        check("rst_ser_done8", ser_done8, 0);
        check("rst_ser_out5", ser_out5, 1);
        check("rst_tx_ready5", tx_ready5, 1);
        check("rst_busy5", busy5, 0);
        check("rst_ser_done5", ser_done5, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Table of frames on the 8-bit instance.
        for (int i = 0; i < 6; i++) begin
            d0 = done8;
            send(1'b0, vecs[i].data, vecs[i].par_en, vecs[i].par_typ, vecs[i].exp_bits, acc);
            wait_done(1'b0, 300);
            repeat (3) @(negedge clk);
            check($sformatf("vec%0d_done_pulses", i), done8 - d0, 1);
            check($sformatf("vec%0d_bits_left", i), q8.size(), 0);
            check($sformatf("vec%0d_ready", i), tx_ready8, 1);
            check($sformatf("vec%0d_idle_line", i), ser_out8, 1);
        end

        // Reset during data bit 3, then a clean frame.
        d0 = done8;
        p0 = popped8;
        send(1'b0, 8'hC3, 1'b0, PAR_EVEN, frame8n1(8'hC3), acc);
        n = 0;
        while (popped8 - p0 < 5 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (popped8 - p0 < 5) fail_now("t3_reach_bit3");
        check("t3_bit3_before_reset", ser_out8, 0);
        #1 rst = 1'b1;
        #1;
        check("t3_line_high_async", ser_out8, 1);
        check("t3_ready_async", tx_ready8, 1);
        check("t3_busy_async", busy8, 0);
        q8.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("t3_no_done", done8 - d0, 0);
        send(1'b0, 8'h3C, 1'b0, PAR_EVEN, frame8n1(8'h3C), acc);
        wait_done(1'b0, 300);
        repeat (3) @(negedge clk);
        check("t3_after_done_pulses", done8 - d0, 1);
        check("t3_after_bits_left", q8.size(), 0);

        // TX_valid pulse while busy is ignored.
        d0 = done8;
        send(1'b0, 8'h12, 1'b0, PAR_EVEN, frame8n1(8'h12), acc);
        repeat (10) @(negedge clk);
        data8 = 8'hFF;
        valid8 = 1'b1;
        @(negedge clk);
        valid8 = 1'b0;
        check("t4_busy_mid_frame", busy8, 1);
        wait_done(1'b0, 300);
        repeat (40) @(negedge clk);
        check("t4_single_frame", done8 - d0, 1);
        check("t4_bits_left", q8.size(), 0);
        check("t4_idle_after", busy8, 0);

        // Back-to-back frames: second accept lands in the IDLE cycle right after ser_done.
        d0 = done8;
        send(1'b0, 8'h55, 1'b0, PAR_EVEN, frame8n1(8'h55), acc);
        send(1'b0, 8'hAA, 1'b0, PAR_EVEN, frame8n1(8'hAA), acc2);
        check("t4_first_done_before_second", done8 - d0, 1);
        check("t4_accept_after_done", acc2 - done8_cyc, 1);
        wait_done(1'b0, 300);
        repeat (3) @(negedge clk);
        check("t4_two_done_pulses", done8 - d0, 2);
        check("t4_b2b_bits_left", q8.size(), 0);

        // 5-bit MSB-first, two stop bits.
        d0 = done5;
        send(1'b1, 8'h16, 1'b0, PAR_EVEN, "01011011", acc);
        wait_done(1'b1, 400);
        repeat (3) @(negedge clk);
        check("t5_done_pulses", done5 - d0, 1);
        check("t5_bits_left", q5.size(), 0);

        // Tick coincident with the accept edge must not start the frame.
        tick_periodic = 1'b0;
        repeat (3) @(negedge clk);
        d0 = done5;
        data5 = 5'b01101;
        valid5 = 1'b1;
        tick_force = 1'b1;
        q5.push_back(1'b0); q5.push_back(1'b0); q5.push_back(1'b1); q5.push_back(1'b1);
        q5.push_back(1'b0); q5.push_back(1'b1); q5.push_back(1'b1); q5.push_back(1'b1);
        @(negedge clk);
        valid5 = 1'b0;
        tick_force = 1'b0;
        check("t5_arm_line_high", ser_out5, 1);
        check("t5_arm_busy", busy5, 1);
        tick_periodic = 1'b1;
        wait_done(1'b1, 400);
        repeat (3) @(negedge clk);
        check("t5_coincident_done", done5 - d0, 1);
        check("t5_coincident_bits_left", q5.size(), 0);

        // Tick held high: one bit per clock; mid-frame PAR_EN/data changes ignored.
        tick_periodic = 1'b0;
        tick_hold = 1'b1;
        repeat (3) @(negedge clk);
        d0 = done8;
        send(1'b0, 8'h81, 1'b0, PAR_EVEN, frame8n1(8'h81), acc);
        par_en = 1'b1;
        par_typ = PAR_ODD;
        data8 = 8'h00;
        wait_done(1'b0, 100);
        check("t6_start_to_done_cycles", done8_cyc - (acc + 1), 10);
        repeat (3) @(negedge clk);
        check("t6_done_pulses", done8 - d0, 1);
        check("t6_bits_left", q8.size(), 0);
        tick_hold = 1'b0;
        tick_periodic = 1'b1;
        repeat (5) @(negedge clk);

        check("final_q8_empty", q8.size(), 0);
        check("final_q5_empty", q5.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run exceeded its time limit after %0d checks", checks);
        $fatal(1, "watchdog expired");
    end

endmodule
